// File: rtl/game_flow_ctrl.sv
// Game state controller: menu -> round -> win/lose end screen -> menu.
// Tracks both tanks' hit points and drives the end-screen overlay selection.
module game_flow_ctrl #(
    parameter int HP_INIT = 3,
    parameter int BTN_X   = 384,
    parameter int BTN_Y   = 320,
    parameter int BTN_W   = 256,
    parameter int BTN_H   = 64,
    parameter int GRACE   = 6500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mouse_left,
    input  logic [11:0] xpos_mouse_in,
    input  logic [11:0] ypos_mouse_in,
    input  logic        hit_enemy,
    input  logic        hit_player,
    input  logic        back_to_menu,
    output logic        select,
    output logic [1:0]  game_end,
    output logic        new_game,
    output logic [2:0]  player_hp,
    output logic [2:0]  enemy_hp
);

    typedef enum logic [1:0] {MENU, PLAY, WIN, LOSE} state_t;

    localparam logic [2:0]  HP_I = 3'(HP_INIT);
    localparam logic [22:0] GR   = 23'(GRACE);
    // 13-bit bounds so BTN_X+BTN_W cannot wrap against a 12-bit cursor.
    localparam logic [12:0] X_LO = 13'(BTN_X);
    localparam logic [12:0] X_HI = 13'(BTN_X + BTN_W);
    localparam logic [12:0] Y_LO = 13'(BTN_Y);
    localparam logic [12:0] Y_HI = 13'(BTN_Y + BTN_H);

    state_t      state, state_n;
    logic [22:0] grace, grace_n;
    logic        mouse_prev;
    logic        click, in_btn;
    logic        select_n, new_game_n;
    logic [1:0]  game_end_n;
    logic [2:0]  player_hp_n, enemy_hp_n;

    assign click  = mouse_left && !mouse_prev;
    assign in_btn = ({1'b0, xpos_mouse_in} >= X_LO) && ({1'b0, xpos_mouse_in} < X_HI) &&
                    ({1'b0, ypos_mouse_in} >= Y_LO) && ({1'b0, ypos_mouse_in} < Y_HI);

    always_comb begin
        state_n     = state;
        grace_n     = grace;
        new_game_n  = 1'b0;
        player_hp_n = player_hp;
        enemy_hp_n  = enemy_hp;
        case (state)
            MENU: begin
                if (click && in_btn) begin
                    state_n     = PLAY;
                    new_game_n  = 1'b1;
                    player_hp_n = HP_I;
                    enemy_hp_n  = HP_I;
                    grace_n     = GR;
                end
            end
            PLAY: begin
                if (grace != 23'd0) begin
                    grace_n = grace - 23'd1;
                end else begin
                    if (hit_enemy && enemy_hp != 3'd0)   enemy_hp_n  = enemy_hp - 3'd1;
                    if (hit_player && player_hp != 3'd0) player_hp_n = player_hp - 3'd1;
                    // A double kill counts against the player.
                    if (player_hp_n == 3'd0)     state_n = LOSE;
                    else if (enemy_hp_n == 3'd0) state_n = WIN;
                end
            end
            WIN, LOSE: begin
                if (back_to_menu) begin
                    state_n     = MENU;
                    player_hp_n = HP_I;
                    enemy_hp_n  = HP_I;
                end
            end
            default: begin
                state_n     = MENU;
                grace_n     = 23'd0;
                player_hp_n = HP_I;
                enemy_hp_n  = HP_I;
            end
        endcase
        select_n   = (state_n != MENU);
        game_end_n = (state_n == WIN) ? 2'd1 : (state_n == LOSE) ? 2'd2 : 2'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= MENU;
            grace      <= 23'd0;
            mouse_prev <= 1'b1;
            select     <= 1'b0;
            game_end   <= 2'd0;
            new_game   <= 1'b0;
            player_hp  <= HP_I;
            enemy_hp   <= HP_I;
        end else begin
            state      <= state_n;
            grace      <= grace_n;
            mouse_prev <= mouse_left;
            select     <= select_n;
            game_end   <= game_end_n;
            new_game   <= new_game_n;
            player_hp  <= player_hp_n;
            enemy_hp   <= enemy_hp_n;
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed vector bench for game_flow_ctrl with a short grace window.
module tb_game_flow_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mouse_left;
    logic [11:0] xpos_mouse_in, ypos_mouse_in;
    logic        hit_enemy, hit_player, back_to_menu;
    logic        select;
    logic [1:0]  game_end;
    logic        new_game;
    logic [2:0]  player_hp, enemy_hp;

    int tests = 0;
    int fails = 0;

    game_flow_ctrl #(.HP_INIT(3), .GRACE(10)) dut (
        .clk(clk), .rst(rst), .mouse_left(mouse_left),
        .xpos_mouse_in(xpos_mouse_in), .ypos_mouse_in(ypos_mouse_in),
        .hit_enemy(hit_enemy), .hit_player(hit_player), .back_to_menu(back_to_menu),
        .select(select), .game_end(game_end), .new_game(new_game),
        .player_hp(player_hp), .enemy_hp(enemy_hp)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          reps;
        logic        m;
        logic [11:0] x, y;
        logic        he, hp, btm;
        logic        sel;
        logic [1:0]  ge;
        logic        ng;
        logic [2:0]  php, ehp;
    } vec_t;

    vec_t v[34];

    task automatic check(input string name, input logic s, input logic [1:0] g,
                         input logic n, input logic [2:0] p, input logic [2:0] e);
        logic [9:0] act, exp;
        act = {select, game_end, new_game, player_hp, enemy_hp};
        exp = {s, g, n, p, e};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got sel=%b ge=%0d ng=%b php=%0d ehp=%0d, want sel=%b ge=%0d ng=%b php=%0d ehp=%0d",
                     name, select, game_end, new_game, player_hp, enemy_hp, s, g, n, p, e);
        end
    endtask

    task automatic drive(input logic m, input logic [11:0] x, input logic [11:0] y,
                         input logic he, input logic hp, input logic btm);
        mouse_left = m; xpos_mouse_in = x; ypos_mouse_in = y;
        hit_enemy = he; hit_player = hp; back_to_menu = btm;
    endtask

    function automatic vec_t mk(int r, logic m, int x, int y, logic he, logic hp, logic btm,
                                logic s, int g, logic n, int p, int e);
        vec_t t;
        t.reps = r; t.m = m; t.x = 12'(x); t.y = 12'(y);
        t.he = he; t.hp = hp; t.btm = btm;
        t.sel = s; t.ge = 2'(g); t.ng = n; t.php = 3'(p); t.ehp = 3'(e);
        return t;
    endfunction

    initial begin
        //           reps m  x    y    he hp bt  sel ge ng p  e
        v[0]  = mk(1, 1, 400, 330, 0, 0, 0,  0, 0, 0, 3, 3); // held through reset: no click
        v[1]  = mk(1, 0, 400, 330, 0, 0, 0,  0, 0, 0, 3, 3);
        v[2]  = mk(1, 1, 100, 100, 0, 0, 0,  0, 0, 0, 3, 3); // outside
        v[3]  = mk(1, 0, 100, 100, 0, 0, 0,  0, 0, 0, 3, 3);
        v[4]  = mk(1, 1, 640, 330, 0, 0, 0,  0, 0, 0, 3, 3); // right edge excluded
        v[5]  = mk(1, 0, 640, 330, 0, 0, 0,  0, 0, 0, 3, 3);
        v[6]  = mk(1, 1, 400, 384, 0, 0, 0,  0, 0, 0, 3, 3); // bottom edge excluded
        v[7]  = mk(1, 0, 400, 384, 0, 0, 0,  0, 0, 0, 3, 3);
        v[8]  = mk(1, 1, 384, 320, 0, 0, 0,  1, 0, 1, 3, 3); // top-left corner starts
        v[9]  = mk(1, 1, 384, 320, 0, 0, 0,  1, 0, 0, 3, 3); // grace 10->9
        v[10] = mk(1, 0, 0,   0,   0, 0, 1,  1, 0, 0, 3, 3); // btm in PLAY ignored
        v[11] = mk(2, 0, 0,   0,   0, 0, 0,  1, 0, 0, 3, 3);
        v[12] = mk(1, 0, 0,   0,   1, 0, 0,  1, 0, 0, 3, 3); // cycle 5: in grace
        v[13] = mk(4, 0, 0,   0,   0, 0, 0,  1, 0, 0, 3, 3);
        v[14] = mk(1, 0, 0,   0,   1, 0, 0,  1, 0, 0, 3, 3); // last grace cycle
        v[15] = mk(1, 0, 0,   0,   0, 0, 0,  1, 0, 0, 3, 3);
        v[16] = mk(1, 0, 0,   0,   1, 0, 0,  1, 0, 0, 3, 2); // cycle 12 counts
        v[17] = mk(1, 0, 0,   0,   1, 0, 0,  1, 0, 0, 3, 1);
        v[18] = mk(1, 0, 0,   0,   0, 1, 0,  1, 0, 0, 2, 1);
        v[19] = mk(1, 0, 0,   0,   1, 0, 0,  1, 1, 0, 2, 0); // WIN
        v[20] = mk(1, 0, 0,   0,   0, 1, 0,  1, 1, 0, 2, 0); // frozen
        v[21] = mk(1, 0, 0,   0,   1, 0, 0,  1, 1, 0, 2, 0);
        v[22] = mk(1, 1, 400, 330, 0, 0, 1,  0, 0, 0, 3, 3); // click + btm
        v[23] = mk(1, 1, 400, 330, 0, 0, 0,  0, 0, 0, 3, 3); // still held: no start
        v[24] = mk(1, 0, 400, 330, 0, 0, 1,  0, 0, 0, 3, 3); // btm in MENU
        v[25] = mk(1, 1, 400, 330, 0, 0, 0,  1, 0, 1, 3, 3);
        v[26] = mk(10,0, 0,   0,   0, 0, 0,  1, 0, 0, 3, 3);
        v[27] = mk(1, 0, 0,   0,   1, 1, 0,  1, 0, 0, 2, 2);
        v[28] = mk(1, 0, 0,   0,   1, 1, 0,  1, 0, 0, 1, 1);
        v[29] = mk(1, 0, 0,   0,   1, 1, 0,  1, 2, 0, 0, 0); // tie -> LOSE
        v[30] = mk(1, 0, 0,   0,   0, 1, 0,  1, 2, 0, 0, 0);
        v[31] = mk(2, 0, 0,   0,   0, 0, 0,  1, 2, 0, 0, 0);
        v[32] = mk(1, 0, 0,   0,   0, 0, 1,  0, 0, 0, 3, 3);
        v[33] = mk(1, 0, 0,   0,   0, 0, 1,  0, 0, 0, 3, 3);

        rst = 1'b1;
        drive(1, 400, 330, 0, 0, 0);
        #3;
        check("reset", 0, 0, 0, 3, 3);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 34; i++) begin
            for (int r = 0; r < v[i].reps; r++) begin
                @(negedge clk);
                drive(v[i].m, v[i].x, v[i].y, v[i].he, v[i].hp, v[i].btm);
                @(posedge clk);
                #1;
                check($sformatf("vec%0d.%0d", i, r), v[i].sel, v[i].ge, v[i].ng, v[i].php, v[i].ehp);
            end
        end

        // Async reset mid-round with the button held.
        @(negedge clk);
        drive(1, 400, 330, 0, 0, 0);
        @(posedge clk); #1;
        check("restart", 1, 0, 1, 3, 3);
        @(negedge clk);
        @(posedge clk); #1;
        check("restart_hold", 1, 0, 0, 3, 3);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 0, 0, 0, 3, 3);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_hold", 0, 0, 0, 3, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
